mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-ported unified memory between the CPU's instruction-fetch path and its load/store data path. Accepts one request at a time from either side and drives it onto the memory port. Waits for the memory's acknowledge, or a timeout, then returns a one-cycle completion pulse with read data to the winning requester. Sits between the CPU core and the memory, and is the step from separate instruction/data memories to a single shared memory with variable latency.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, data port and memory port.
// The arbiter uses the slave view; the CPU/memory environment uses master.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    localparam int BW = WIDTH / 8;

    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [WIDTH-1:0] if_rdata;
    logic             if_err;

    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic [BW-1:0]    d_be;
    logic             d_gnt;
    logic             d_rvalid;
    logic [WIDTH-1:0] d_rdata;
    logic             d_err;

    logic             m_req;
    logic             m_we;
    logic [WIDTH-1:0] m_addr;
    logic [WIDTH-1:0] m_wdata;
    logic [BW-1:0]    m_be;
    logic             m_ack;
    logic [WIDTH-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ack, m_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving instruction fetch and load/store one shared
// single-ported memory, with a bounded wait for the memory acknowledge.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input logic        clk,
    input logic        rst,
    mem_arbiter_if.slave bus
);
    localparam int BW = WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             last_d_q, last_d_d;

    logic             m_we_q, m_we_d;
    logic [WIDTH-1:0] m_addr_q, m_addr_d;
    logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [BW-1:0]    m_be_q, m_be_d;

    logic             if_rvalid_q, if_rvalid_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic             if_err_q, if_err_d;
    logic             d_rvalid_q, d_rvalid_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic             d_err_q, d_err_d;

    logic             if_gnt, d_gnt;
    logic             ack, tmo, done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_be_d      = m_be_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        ack         = 1'b0;
        tmo         = 1'b0;
        done        = 1'b0;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // On a tie, the side that did not win last time goes first
                if (rst && bus.if_req && (!bus.d_req || last_d_q)) begin
                    if_gnt    = 1'b1;
                    state_d   = BUSY_IF;
                    last_d_d  = 1'b0;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.if_addr;
                    m_wdata_d = '0;
                    m_be_d    = '1;
                end else if (rst && bus.d_req) begin
                    d_gnt     = 1'b1;
                    state_d   = BUSY_D;
                    last_d_d  = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_be_d    = bus.d_be;
                end
            end
            BUSY_IF, BUSY_D: begin
                // An ack in the final allowed cycle still completes normally
                ack  = bus.m_ack;
                tmo  = !bus.m_ack && (cnt_inc == CNT_MAX);
                done = ack || tmo;
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (done && state_q == BUSY_IF) begin
                    if_rvalid_d = 1'b1;
                    if_err_d    = tmo;
                    if_rdata_d  = ack ? bus.m_rdata : '0;
                end
                if (done && state_q == BUSY_D) begin
                    d_rvalid_d = 1'b1;
                    d_err_d    = tmo;
                    d_rdata_d  = (ack && !m_we_q) ? bus.m_rdata : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_d_q    <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_be_q      <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_d_q    <= last_d_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_be_q      <= m_be_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.m_req     = (state_q != IDLE);
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_be      = m_be_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, memory responder, grant/latency
// model and completion scoreboard.
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(W)) bus ();

    mem_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          do_if;
        logic [31:0] ia;
        bit          do_d;
        bit          we;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  be;
        int          lat;
        bit          exp_first_d;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          side;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ack_lat = 1;
    int          mc = 0;
    int          busy_start = 0;
    int          free_cyc = 0;
    bit          m_last_d = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic        cur_we = 1'b0;
    logic [3:0]  cur_be = '0;
    logic [31:0] last_if_rdata = '0;
    logic [31:0] last_d_rdata = '0;
    logic        last_if_err = 1'b0;
    logic        last_d_err = 1'b0;
    bit          last_cpl_err = 1'b0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5AA5A5);
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_wait(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait expired, got no event, expected one (cycle %0d)", name, cyc);
    endfunction

    function automatic void cpl(input bit side, input logic [31:0] rd, input logic er);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rvalid: got rvalid side=%0d expected none (cycle %0d)",
                     side, cyc);
        end else begin
            e = sb.pop_front();
            check("cpl_side", side, e.side);
            check("cpl_rdata", rd, e.rdata);
            check("cpl_err", er, e.err);
            check("cpl_cycle", cyc, e.cyc);
        end
        last_cpl_err = er;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: acks in the ack_lat-th cycle of m_req (0 = never)
    always @(negedge clk) begin
        if (bus.m_req === 1'b1) begin
            mc++;
            bus.m_ack   = (ack_lat != 0) && (mc == ack_lat);
            bus.m_rdata = bus.m_ack ? mem_model(bus.m_addr) : 32'h0;
        end else begin
            mc          = 0;
            bus.m_ack   = 1'b0;
            bus.m_rdata = 32'h0;
        end
    end

    always @(negedge clk) begin : mon
        bit          exp_mreq, idle, eg_if, eg_d, to;
        int          dur;
        logic [31:0] rd;
        exp_mreq = (cyc >= busy_start) && (cyc < free_cyc);
        check("m_req", bus.m_req, exp_mreq);
        if (exp_mreq && bus.m_req === 1'b1) begin
            check("m_addr", bus.m_addr, cur_addr);
            check("m_we", bus.m_we, cur_we);
            check("m_wdata", bus.m_wdata, cur_wdata);
            check("m_be", bus.m_be, cur_be);
        end
        if (bus.if_rvalid === 1'b1) begin
            cpl(1'b0, bus.if_rdata, bus.if_err);
            last_if_rdata = bus.if_rdata;
            last_if_err   = bus.if_err;
        end else begin
            check("if_rvalid", bus.if_rvalid, 1'b0);
            check("if_rdata_hold", bus.if_rdata, last_if_rdata);
            check("if_err_hold", bus.if_err, last_if_err);
        end
        if (bus.d_rvalid === 1'b1) begin
            cpl(1'b1, bus.d_rdata, bus.d_err);
            last_d_rdata = bus.d_rdata;
            last_d_err   = bus.d_err;
        end else begin
            check("d_rvalid", bus.d_rvalid, 1'b0);
            check("d_rdata_hold", bus.d_rdata, last_d_rdata);
            check("d_err_hold", bus.d_err, last_d_err);
        end
        idle  = (cyc >= free_cyc);
        eg_if = (rst === 1'b1) && idle && bus.if_req && (!bus.d_req || m_last_d);
        eg_d  = (rst === 1'b1) && idle && bus.d_req && !eg_if;
        if (bus.if_req || bus.d_req || bus.if_gnt || bus.d_gnt) begin
            check("if_gnt", bus.if_gnt, eg_if);
            check("d_gnt", bus.d_gnt, eg_d);
        end
        if (eg_if || eg_d) begin
            to         = (ack_lat == 0) || (ack_lat > TO);
            dur        = to ? TO : ack_lat;
            busy_start = cyc + 1;
            free_cyc   = cyc + dur + 1;
            m_last_d   = eg_d;
            if (eg_d) begin
                cur_we    = bus.d_we;
                cur_addr  = bus.d_addr;
                cur_wdata = bus.d_wdata;
                cur_be    = bus.d_be;
            end else begin
                cur_we    = 1'b0;
                cur_addr  = bus.if_addr;
                cur_wdata = 32'h0;
                cur_be    = 4'hF;
            end
            rd = (to || cur_we) ? 32'h0 : mem_model(cur_addr);
            sb.push_back('{eg_d, rd, to, cyc + dur + 1});
        end
        if (rst !== 1'b1) begin
            busy_start    = cyc + 1;
            free_cyc      = cyc + 1;
            m_last_d      = 1'b0;
            sb.delete();
            last_if_rdata = '0;
            last_d_rdata  = '0;
            last_if_err   = 1'b0;
            last_d_err    = 1'b0;
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) fail_wait(name);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit pend_if, pend_d, got, first_d;
        int n = 0;
        got     = 1'b0;
        first_d = 1'b0;
        ack_lat = v.lat;
        bus.if_req  = v.do_if;
        bus.if_addr = v.ia;
        bus.d_req   = v.do_d;
        bus.d_we    = v.we;
        bus.d_addr  = v.da;
        bus.d_wdata = v.wd;
        bus.d_be    = v.be;
        pend_if = v.do_if;
        pend_d  = v.do_d;
        while ((pend_if || pend_d) && n < 100) begin
            @(negedge clk);
            if (pend_if && bus.if_gnt === 1'b1) begin
                pend_if = 1'b0;
                if (!got) first_d = 1'b0;
                got = 1'b1;
            end
            if (pend_d && bus.d_gnt === 1'b1) begin
                pend_d = 1'b0;
                if (!got) first_d = 1'b1;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!pend_if) bus.if_req = 1'b0;
            if (!pend_d) bus.d_req = 1'b0;
            n++;
        end
        if (pend_if || pend_d) begin
            fail_wait($sformatf("vec%0d_grant", idx));
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
        end else begin
            check($sformatf("vec%0d_first_grant", idx), first_d, v.exp_first_d);
        end
        wait_drain($sformatf("vec%0d_drain", idx));
        check($sformatf("vec%0d_err", idx), last_cpl_err, v.exp_err);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,    1,  1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h40, 32'h0,        4'h0,    1,  1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h204, 1'b1, 1'b0, 32'h44, 32'h0,        4'h0,    1,  1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011, 3,  1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h48, 32'h0,        4'h0,    0,  1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,    15, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h304, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,    16, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 32'h308, 1'b1, 1'b1, 32'h4C, 32'hCAFEF00D, 4'b1100, 2,  1'b1, 1'b0};
        vecs[8] = '{1'b1, 32'h500, 1'b1, 1'b0, 32'h64, 32'h0,        4'h0,    1,  1'b1, 1'b0};

        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_be    = 4'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_if_gnt", bus.if_gnt, 1'b0);
        check("rst_d_gnt", bus.d_gnt, 1'b0);
        check("rst_m_req", bus.m_req, 1'b0);
        check("rst_m_we", bus.m_we, 1'b0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        check("rst_m_wdata", bus.m_wdata, 32'h0);
        check("rst_m_be", bus.m_be, 4'h0);
        check("rst_if_rvalid", bus.if_rvalid, 1'b0);
        check("rst_d_rvalid", bus.d_rvalid, 1'b0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_if_err", bus.if_err, 1'b0);
        check("rst_d_err", bus.d_err, 1'b0);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Data access times out; a waiting fetch is granted in the error cycle
        ack_lat     = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h50;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.d_gnt !== 1'b1 && n < 20);
        if (bus.d_gnt !== 1'b1) fail_wait("tmo_d_grant");
        @(posedge clk);
        #1;
        bus.d_req   = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.if_gnt !== 1'b1 && n < 40);
        if (bus.if_gnt !== 1'b1) begin
            fail_wait("tmo_if_grant");
        end else begin
            check("grant_with_err_rvalid", bus.d_rvalid, 1'b1);
            check("grant_with_err_flag", bus.d_err, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        wait_drain("tmo_drain");

        // Reset in the middle of a data access
        ack_lat    = 0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h60;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.d_gnt !== 1'b1 && n < 20);
        if (bus.d_gnt !== 1'b1) fail_wait("rst_d_grant");
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_req", bus.m_req, 1'b0);
        check("midrst_d_rvalid", bus.d_rvalid, 1'b0);
        check("midrst_m_addr", bus.m_addr, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        run_vec(vecs[8], 8);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
